// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the fifo_gen family.
// Sizing functions are elaboration-time only and feed port and pointer widths.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Occupancy runs 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, registered read that
// holds its last value while no read is requested.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; same-address read/write returns the old word
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/fifo_gen.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags around a fifo_ram array.
module fifo_gen
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          clr_err,
    output logic [WIDTH-1:0]              data_out,
    output logic                          en,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             en_q, en_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             seen_q, seen_d;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] rdata;

    assign pop_ok  = pop && !fifo_empty && !reset;
    assign push_ok = push && (!fifo_full || pop_ok) && !reset;

    // Next-state for pointers, occupancy, read strobe and error flags
    always_comb begin
        wp_d    = push_ok ? wp_q + AW'(1) : wp_q;
        rp_d    = pop_ok  ? rp_q + AW'(1) : rp_q;
        en_d    = pop_ok;
        seen_d  = seen_q | pop_ok;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as clr_err keeps the flag set
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (pop && !pop_ok) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // State registers; requests seen while reset is high are discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q    <= {AW{1'b0}};
            rp_q    <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            seen_q  <= seen_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wp_q),
        .wdata (data_in),
        .re    (pop_ok),
        .raddr (rp_q),
        .rdata (rdata)
    );

    // The array read register has no reset, so data_out reads zero until the
    // first pop after reset.
    assign data_out     = seen_q ? rdata : {WIDTH{1'b0}};
    assign en           = en_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign fifo_full    = (count_q == FULL_C);
    assign fifo_empty   = (count_q == {CW{1'b0}});
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

endmodule
